// File: rtl/slider_ctrl_pkg.sv
// Shared register-map constants and reset defaults for the slider input controller.
package slider_ctrl_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA  = 2'd0,
        ADDR_MASK  = 2'd1,
        ADDR_EDGE  = 2'd2,
        ADDR_LIMIT = 2'd3
    } reg_addr_e;

    // 1 ms at 50 MHz
    localparam logic [19:0] DEFAULT_LIMIT = 20'd50000;

endpackage

// File: rtl/slider_debounce_bit.sv
// One slider bit: 2-flop synchroniser, debounce counter and stable flop,
// with a single-cycle pulse on the cycle the stable value changes.
module slider_debounce_bit #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pin,
    input  logic [CNT_W-1:0] i_limit,
    output logic             o_stable,
    output logic             o_edge
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_commit;

    assign w_diff   = (r_sync2 != r_stable);
    // >= so that lowering the limit below a running count commits on the next edge
    assign w_commit = w_diff && (r_cnt >= i_limit);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_commit) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
    assign o_edge   = w_commit & i_rst_n;

endmodule

// File: rtl/slider_input_ctrl.sv
// Avalon-MM slider controller: per-bit debounce, DATA/MASK/EDGE/LIMIT register
// file with write-1-to-clear edge capture and a level interrupt.
module slider_input_ctrl
    import slider_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH         = 10,
    parameter int unsigned      CNT_W         = 20,
    parameter logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(slider_ctrl_pkg::DEFAULT_LIMIT)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edge;
    logic [CNT_W-1:0] r_limit;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge_set;
    logic [WIDTH-1:0] w_edge_clr;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_unused_wdata = ^writedata[31:CNT_W];

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        slider_debounce_bit #(
            .CNT_W(CNT_W)
        ) u_bit (
            .i_clk    (clk),
            .i_rst_n  (reset_n),
            .i_pin    (in_port[g]),
            .i_limit  (r_limit),
            .o_stable (w_stable[g]),
            .o_edge   (w_edge_set[g])
        );
    end

    assign w_edge_clr = (write && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:  w_rd_mux[WIDTH-1:0] = w_stable;
            ADDR_MASK:  w_rd_mux[WIDTH-1:0] = r_mask;
            ADDR_EDGE:  w_rd_mux[WIDTH-1:0] = r_edge;
            ADDR_LIMIT: w_rd_mux[CNT_W-1:0] = r_limit;
            default:    w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mask   <= '0;
            r_edge   <= '0;
            r_limit  <= DEFAULT_LIMIT;
            readdata <= '0;
        end else begin
            if (write && (address == ADDR_MASK)) begin
                r_mask <= writedata[WIDTH-1:0];
            end
            if (write && (address == ADDR_LIMIT)) begin
                r_limit <= writedata[CNT_W-1:0];
            end
            // set wins over a coinciding W1C clear
            r_edge   <= (r_edge & ~w_edge_clr) | w_edge_set;
            readdata <= w_rd_mux;
        end
    end

    assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_slider_input_ctrl.sv
// Self-checking bench for slider_input_ctrl: register-map vector table plus
// timed sequences for debounce, interrupt, collision and mid-count reset.
module tb_slider_input_ctrl;
    import slider_ctrl_pkg::*;

    localparam int unsigned WIDTH = 10;

    logic             clk       = 1'b0;
    logic             reset_n   = 1'b0;
    logic [1:0]       address   = '0;
    logic             write     = 1'b0;
    logic [31:0]      writedata = '0;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port   = '0;
    logic             irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        bit          chk_rd;
        logic [31:0] rd;
        logic        irq;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[6];

    slider_input_ctrl #(
        .WIDTH(10),
        .CNT_W(20),
        .DEFAULT_LIMIT(20'd50000)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expectation is queued when the cycle's stimulus is in place, then
    // retired against the DUT outputs just after the edge.
    task automatic step(input string nm, input bit chk_rd, input logic [31:0] rd, input logic irq_e);
        exp_t e;
        e.name   = nm;
        e.chk_rd = chk_rd;
        e.rd     = rd;
        e.irq    = irq_e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk_rd) check({e.name, ".readdata"}, readdata, e.rd);
        check({e.name, ".irq"}, {31'b0, irq}, {31'b0, e.irq});
    endtask

    task automatic wr_cycle(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{name: "map_mask_ones",  addr: ADDR_MASK,  wdata: 32'hFFFF_FFFF, exp_rd: 32'h0000_03FF};
        vecs[1] = '{name: "map_limit_ones", addr: ADDR_LIMIT, wdata: 32'hFFFF_FFFF, exp_rd: 32'h000F_FFFF};
        vecs[2] = '{name: "map_data_ro",    addr: ADDR_DATA,  wdata: 32'hFFFF_FFFF, exp_rd: 32'h0000_0000};
        vecs[3] = '{name: "map_edge_w1c",   addr: ADDR_EDGE,  wdata: 32'hFFFF_FFFF, exp_rd: 32'h0000_0000};
        vecs[4] = '{name: "map_mask_1",     addr: ADDR_MASK,  wdata: 32'h0000_0001, exp_rd: 32'h0000_0001};
        vecs[5] = '{name: "map_limit_4",    addr: ADDR_LIMIT, wdata: 32'h0000_0004, exp_rd: 32'h0000_0004};

        // Reset held with all sliders up
        reset_n = 1'b0;
        in_port = 10'h3FF;
        address = ADDR_LIMIT;
        for (int i = 0; i < 3; i++) step($sformatf("reset_c%0d", i), 1'b1, 32'h0, 1'b0);
        reset_n = 1'b1;
        in_port = '0;
        step("limit_default", 1'b1, 32'd50000, 1'b0);

        for (int i = 0; i < 6; i++) begin
            wr_cycle(vecs[i].addr, vecs[i].wdata);
            address = vecs[i].addr;
            step(vecs[i].name, 1'b1, vecs[i].exp_rd, 1'b0);
        end

        // Clean change with L=4, MASK=1: stable at edge 6, readdata shows it at edge 7
        address = ADDR_DATA;
        in_port = 10'h001;
        for (int k = 0; k <= 7; k++)
            step($sformatf("clean_e%0d", k), 1'b1, (k == 7) ? 32'h1 : 32'h0, (k >= 6));
        address = ADDR_EDGE;
        step("clean_edge", 1'b1, 32'h1, 1'b1);
        writedata = 32'h1;
        write     = 1'b1;
        step("clean_clear", 1'b1, 32'h1, 1'b0);
        write     = 1'b0;
        step("clean_clear_read", 1'b1, 32'h0, 1'b0);

        // Glitches of 3 and 4 cycles on bit 3 are rejected with L=4
        wr_cycle(ADDR_MASK, 32'h008);
        for (int w = 3; w <= 4; w++) begin
            in_port[3] = 1'b1;
            tick(w);
            in_port[3] = 1'b0;
            address = ADDR_DATA;
            for (int k = 0; k < 8; k++) step($sformatf("bounce%0d_c%0d", w, k), 1'b1, 32'h1, 1'b0);
            address = ADDR_EDGE;
            step($sformatf("bounce%0d_edge", w), 1'b1, 32'h0, 1'b0);
        end

        // Interrupt on bit 9 with L=0
        wr_cycle(ADDR_MASK, 32'h200);
        wr_cycle(ADDR_LIMIT, 32'h0);
        in_port[9] = 1'b1;
        address = ADDR_EDGE;
        for (int k = 0; k <= 2; k++) step($sformatf("irq_e%0d", k), 1'b1, 32'h0, (k == 2));
        writedata = 32'h200;
        write     = 1'b1;
        step("irq_clear", 1'b1, 32'h200, 1'b0);
        write     = 1'b0;
        step("irq_clear_read", 1'b1, 32'h0, 1'b0);

        // W1C on EDGE[0] coinciding with a bit-0 edge event
        wr_cycle(ADDR_MASK, 32'h001);
        in_port[0] = 1'b0;
        step("col_e0", 1'b0, 32'h0, 1'b0);
        step("col_e1", 1'b0, 32'h0, 1'b0);
        address   = ADDR_EDGE;
        writedata = 32'h1;
        write     = 1'b1;
        step("col_e2", 1'b1, 32'h0, 1'b1);
        write     = 1'b0;
        step("col_e3", 1'b1, 32'h1, 1'b1);

        // Reset in the middle of a 100-cycle count
        wr_cycle(ADDR_LIMIT, 32'd100);
        in_port[0] = 1'b1;
        tick(52);
        address = ADDR_DATA;
        step("pre_reset", 1'b1, 32'h200, 1'b1);
        reset_n = 1'b0;
        step("mid_reset_c0", 1'b1, 32'h0, 1'b0);
        step("mid_reset_c1", 1'b1, 32'h0, 1'b0);
        reset_n   = 1'b1;
        address   = ADDR_LIMIT;
        writedata = 32'd100;
        write     = 1'b1;
        tick(1);
        write   = 1'b0;
        address = ADDR_DATA;
        tick(101);
        step("restart_hold", 1'b1, 32'h0, 1'b0);
        step("restart_commit", 1'b1, 32'h201, 1'b0);

        // Lower L from 100 to 10 while cnt=30
        wr_cycle(ADDR_EDGE, 32'h3FF);
        wr_cycle(ADDR_MASK, 32'h201);
        in_port = '0;
        tick(32);
        address   = ADDR_LIMIT;
        writedata = 32'd10;
        write     = 1'b1;
        step("lim_write", 1'b0, 32'h0, 1'b0);
        write   = 1'b0;
        address = ADDR_DATA;
        step("lim_commit", 1'b1, 32'h201, 1'b1);
        step("lim_data", 1'b1, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
